rand_matrix_packer: RTL

//  Consumer stage for the LFSR quantiser's 2-bit random value stream.

---
 rtl/rand_matrix_packer_pkg.sv | 25 ++
 rtl/rand_matrix_packer_if.sv | 29 ++
 rtl/rand_matrix_packer_hist.sv | 33 +++
 rtl/rand_matrix_packer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rand_matrix_packer_pkg.sv
// Shared definitions for the random-matrix packer: FSM state encoding,
// default dimensions and a helper for the index counter width.
package rand_matrix_pkg;

  localparam int N_DEF  = 4;
  localparam int VW_DEF = 2;
  localparam int CW_DEF = 16;
  localparam int ELEMS  = N_DEF * N_DEF;

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    HOLD   = 2'd2
  } pack_state_e;

  // Width of an index covering e elements; never narrower than one bit.
  function automatic int idx_width(input int e);
    if (e > 1) begin
      return $clog2(e);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/rand_matrix_packer_if.sv
// Sample-in / matrix-pair-out port bundle of the random-matrix packer.
// master: the packer itself. slave: the quantiser/multiplier side.
interface rand_matrix_packer_if #(
  parameter int N  = 4,
  parameter int VW = 2,
  parameter int CW = 16
);

  logic                  in_valid;
  logic [VW-1:0]         in_value;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*N*VW-1:0]     out_mat_a;
  logic [N*N*VW-1:0]     out_mat_b;
  logic [CW-1:0]         out_count;
  logic [4*CW-1:0]       hist;

  modport master (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_mat_a, out_mat_b, out_count, hist
  );

  modport slave (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_mat_a, out_mat_b, out_count, hist
  );

endinterface

// File: rtl/rand_matrix_packer_hist.sv
// Four saturating per-value sample counters (values 0..3) used as a
// distribution check of the upstream quantiser. Cleared only by reset.
module rand_matrix_hist #(
  parameter int VW = 2,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          accept,
  input  logic [VW-1:0] value,
  output logic [4*CW-1:0] hist
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] cnt_r [4];

  for (genvar v = 0; v < 4; v++) begin : g_cnt
    // Count accepts carrying value v, holding at the maximum count.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_r[v] <= {CW{1'b0}};
      end else if (accept && (value == VW'(v)) && (cnt_r[v] != CNT_MAX)) begin
        cnt_r[v] <= cnt_r[v] + CW'(1'b1);
      end else begin
        cnt_r[v] <= cnt_r[v];
      end
    end

    assign hist[v*CW +: CW] = cnt_r[v];
  end

endmodule

// File: rtl/rand_matrix_packer.sv
// Random-matrix packer: packs accepted 2-bit samples row-major into
// operand matrices A then B and offers the pair to the multiplier,
// holding it stable until accepted. Samples arriving while the pair is
// held are dropped (upstream free-runs).
// Optional: RAND_MATRIX_PACKER_HIST_EN enables per-value sample counters
// on hist; otherwise hist is tied to zero.
module rand_matrix_packer
  import rand_matrix_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int VW = VW_DEF,
  parameter int CW = CW_DEF
) (
  input logic clock,
  input logic reset,
  rand_matrix_packer_if.master bus
);

  localparam int NE = N * N;
  localparam int IW = idx_width(NE);
  localparam int MW = NE * VW;

  pack_state_e    state_r;
  pack_state_e    state_next_s;
  logic [IW-1:0]  idx_r;
  logic [IW-1:0]  idx_next_s;
  logic           in_ready_r;
  logic           out_valid_r;
  logic [CW-1:0]  out_count_r;
  logic [MW-1:0]  mat_a_r;
  logic [MW-1:0]  mat_b_r;
  logic           accept_s;
  logic           last_s;
  logic           handshake_s;

  // in_ready_r is a registered copy of (state != HOLD), so it can gate accepts.
  assign accept_s = bus.in_valid & in_ready_r;
  assign last_s   = (idx_r == IW'(NE - 1));

  // Next-state and index update for the fill/hold sequence.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    handshake_s  = 1'b0;
    case (state_r)
      FILL_A: begin
        if (accept_s) begin
          if (last_s) begin
            idx_next_s   = {IW{1'b0}};
            state_next_s = FILL_B;
          end else begin
            idx_next_s = idx_r + IW'(1'b1);
          end
        end else begin
          idx_next_s = idx_r;
        end
      end
      FILL_B: begin
        if (accept_s) begin
          if (last_s) begin
            idx_next_s   = {IW{1'b0}};
            state_next_s = HOLD;
          end else begin
            idx_next_s = idx_r + IW'(1'b1);
          end
        end else begin
          idx_next_s = idx_r;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          handshake_s  = 1'b1;
          state_next_s = FILL_A;
          idx_next_s   = {IW{1'b0}};
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = FILL_A;
        idx_next_s   = {IW{1'b0}};
      end
    endcase
  end

  // State, index, handshake flags and pair counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= FILL_A;
      idx_r       <= {IW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_count_r <= {CW{1'b0}};
    end else begin
      state_r     <= state_next_s;
      idx_r       <= idx_next_s;
      in_ready_r  <= (state_next_s != HOLD);
      out_valid_r <= (state_next_s == HOLD);
      if (handshake_s) begin
        out_count_r <= out_count_r + CW'(1'b1);
      end else begin
        out_count_r <= out_count_r;
      end
    end
  end

  // Matrix storage: each accept overwrites exactly one element; old pair
  // contents persist until replaced element by element.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mat_a_r <= {MW{1'b0}};
      mat_b_r <= {MW{1'b0}};
    end else if (accept_s && (state_r == FILL_A)) begin
      mat_a_r[idx_r*VW +: VW] <= bus.in_value;
    end else if (accept_s && (state_r == FILL_B)) begin
      mat_b_r[idx_r*VW +: VW] <= bus.in_value;
    end else begin
      mat_a_r <= mat_a_r;
      mat_b_r <= mat_b_r;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_count = out_count_r;
  assign bus.out_mat_a = mat_a_r;
  assign bus.out_mat_b = mat_b_r;

`ifdef RAND_MATRIX_PACKER_HIST_EN
  rand_matrix_hist #(
    .VW (VW),
    .CW (CW)
  ) u_hist (
    .clock  (clock),
    .reset  (reset),
    .accept (accept_s),
    .value  (bus.in_value),
    .hist   (bus.hist)
  );
`else
  assign bus.hist = {(4*CW){1'b0}};
`endif

endmodule
